sha2_msg_sched: RTL and testbench

SHA2_MSG_SCHED -- requirements
Module: sha2_msg_sched

---
 rtl/sha2_pkg.sv | 58 +++++
 rtl/sha2_sched_sigma.sv | 26 ++
 rtl/sha2_msg_sched.sv | 123 ++++++++++++
 tb/tb_sha2_msg_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - shared types, sigma functions and configuration check for the SHA-2 message scheduler
// Contents:
//   state_t         scheduler FSM states (IDLE, LOAD, EXPAND)
//   *_32 / *_64     rotate/shift amounts for the small sigma functions
//   sig0_32/sig1_32 SHA-256 message-schedule sigma functions
//   sig0_64/sig1_64 SHA-512 message-schedule sigma functions
//   legal_cfg       true only for the (32,64) and (64,80) word-width/round pairings
package sha2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2
    } state_t;

    localparam int S0_R1_32 = 7;
    localparam int S0_R2_32 = 18;
    localparam int S0_SH_32 = 3;
    localparam int S1_R1_32 = 17;
    localparam int S1_R2_32 = 19;
    localparam int S1_SH_32 = 10;

    localparam int S0_R1_64 = 1;
    localparam int S0_R2_64 = 8;
    localparam int S0_SH_64 = 7;
    localparam int S1_R1_64 = 19;
    localparam int S1_R2_64 = 61;
    localparam int S1_SH_64 = 6;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] sig0_32(input logic [31:0] x);
        return rotr32(x, S0_R1_32) ^ rotr32(x, S0_R2_32) ^ (x >> S0_SH_32);
    endfunction

    function automatic logic [31:0] sig1_32(input logic [31:0] x);
        return rotr32(x, S1_R1_32) ^ rotr32(x, S1_R2_32) ^ (x >> S1_SH_32);
    endfunction

    function automatic logic [63:0] sig0_64(input logic [63:0] x);
        return rotr64(x, S0_R1_64) ^ rotr64(x, S0_R2_64) ^ (x >> S0_SH_64);
    endfunction

    function automatic logic [63:0] sig1_64(input logic [63:0] x);
        return rotr64(x, S1_R1_64) ^ rotr64(x, S1_R2_64) ^ (x >> S1_SH_64);
    endfunction

    function automatic bit legal_cfg(input int word_w, input int rounds);
        return ((word_w == 32) && (rounds == 64)) || ((word_w == 64) && (rounds == 80));
    endfunction

endpackage

// File: rtl/sha2_sched_sigma.sv
// rtl/sha2_sched_sigma.sv - combinational next schedule word W_t from the window taps
// Ports:
//   w2   in  WORD_W  W_{t-2}
//   w7   in  WORD_W  W_{t-7}
//   w15  in  WORD_W  W_{t-15}
//   w16  in  WORD_W  W_{t-16}
//   sum  out WORD_W  s1(W_{t-2}) + W_{t-7} + s0(W_{t-15}) + W_{t-16}, modulo 2^WORD_W
module sha2_sched_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] w2,
    input  logic [WORD_W-1:0] w7,
    input  logic [WORD_W-1:0] w15,
    input  logic [WORD_W-1:0] w16,
    output logic [WORD_W-1:0] sum
);

    if (WORD_W == 64) begin : g_sha512
        assign sum = sig1_64(w2) + w7 + sig0_64(w15) + w16;
    end else begin : g_sha256
        assign sum = sig1_32(w2) + w7 + sig0_32(w15) + w16;
    end

endmodule

// File: rtl/sha2_msg_sched.sv
// rtl/sha2_msg_sched.sv - SHA-256/SHA-512 message schedule generator (16 words in, ROUNDS words out)
// Optional feature: define SHA2_MSG_SCHED_ABORT_EN to add the abort input.
// Ports:
//   clk      in   1       rising-edge clock
//   rst      in   1       synchronous active-high reset
//   abort    in   1       (SHA2_MSG_SCHED_ABORT_EN only) drop the current block, same effect as rst
//   m_valid  in   1       message word offered
//   m_ready  out  1       message word accepted
//   m_data   in   WORD_W  message word M_t
//   w_valid  out  1       schedule word valid
//   w_ready  in   1       consumer accepts schedule word
//   w_data   out  WORD_W  schedule word W_t
//   w_idx    out  7       index t of w_data
//   w_last   out  1       w_data is W_{ROUNDS-1}
//   busy     out  1       FSM in LOAD or EXPAND
module sha2_msg_sched
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SHA2_MSG_SCHED_ABORT_EN
    input  logic              abort,
`endif
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [WORD_W-1:0] m_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic [6:0]        w_idx,
    output logic              w_last,
    output logic              busy
);

    if (!legal_cfg(WORD_W, ROUNDS)) begin : g_cfg_check
        $error("sha2_msg_sched: WORD_W/ROUNDS must be 32/64 or 64/80");
    end

    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    state_t            state;
    state_t            state_nx;
    logic              kill;
    logic              adv;
    logic              m_fire;
    logic              gen;
    logic [WORD_W-1:0] sched_sum;
    // win[0] is the oldest word (W_{t-16}), win[15] the newest (W_{t-1}).
    logic [WORD_W-1:0] win [16];

`ifdef SHA2_MSG_SCHED_ABORT_EN
    assign kill = rst | abort;
`else
    assign kill = rst;
`endif

    // The output register can take a new word when it is empty or being drained.
    assign adv    = !w_valid || w_ready;
    assign m_fire = m_valid && m_ready;
    assign gen    = (state == EXPAND) && adv;

    assign w_last = w_valid && (w_idx == LAST_IDX);
    assign busy   = (state == LOAD) || (state == EXPAND);

    sha2_sched_sigma #(
        .WORD_W (WORD_W)
    ) u_sigma (
        .w2  (win[14]),
        .w7  (win[9]),
        .w15 (win[1]),
        .w16 (win[0]),
        .sum (sched_sum)
    );

    always_comb begin
        m_ready  = !kill && (state != EXPAND) && adv;
        state_nx = state;
        case (state)
            IDLE:    if (m_fire) state_nx = LOAD;
            LOAD:    if (m_fire && (w_idx == 7'd14)) state_nx = EXPAND;
            // Leave EXPAND as soon as the final word is generated so that the
            // next block's M_0 can be accepted while that word is drained.
            EXPAND:  if (adv && (w_idx == LAST_IDX - 7'd1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state   <= IDLE;
            w_valid <= 1'b0;
            w_data  <= '0;
            w_idx   <= '0;
        end else begin
            state <= state_nx;
            if (m_fire) begin
                w_valid <= 1'b1;
                w_data  <= m_data;
                w_idx   <= (state == IDLE) ? 7'd0 : w_idx + 7'd1;
            end else if (gen) begin
                w_valid <= 1'b1;
                w_data  <= sched_sum;
                w_idx   <= w_idx + 7'd1;
            end else if (w_ready) begin
                w_valid <= 1'b0;
            end
        end
    end

    // Window contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!kill && (m_fire || gen)) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= m_fire ? m_data : sched_sum;
        end
    end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// tb/tb_sha2_msg_sched.sv - self-checking bench for sha2_msg_sched (SHA-256 and SHA-512 instances)
module tb_sha2_msg_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m_valid32, m_ready32, w_valid32, w_ready32, w_last32, busy32;
    logic [31:0] m_data32, w_data32;
    logic [6:0]  w_idx32;
    logic        m_valid64, m_ready64, w_valid64, w_ready64, w_last64, busy64;
    logic [63:0] m_data64, w_data64;
    logic [6:0]  w_idx64;
`ifdef SHA2_MSG_SCHED_ABORT_EN
    logic        abort32;
`endif

    sha2_msg_sched #(.WORD_W(32), .ROUNDS(64)) dut32 (
        .clk(clk), .rst(rst),
`ifdef SHA2_MSG_SCHED_ABORT_EN
        .abort(abort32),
`endif
        .m_valid(m_valid32), .m_ready(m_ready32), .m_data(m_data32),
        .w_valid(w_valid32), .w_ready(w_ready32), .w_data(w_data32),
        .w_idx(w_idx32), .w_last(w_last32), .busy(busy32)
    );

    sha2_msg_sched #(.WORD_W(64), .ROUNDS(80)) dut64 (
        .clk(clk), .rst(rst),
`ifdef SHA2_MSG_SCHED_ABORT_EN
        .abort(1'b0),
`endif
        .m_valid(m_valid64), .m_ready(m_ready64), .m_data(m_data64),
        .w_valid(w_valid64), .w_ready(w_ready64), .w_data(w_data64),
        .w_idx(w_idx64), .w_last(w_last64), .busy(busy64)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] msg   [2][16];
    logic [63:0] exp_w [2][80];

    logic [63:0] cap_data [$];
    logic [6:0]  cap_idx  [$];
    bit          cap_last [$];
    int          cap_cyc  [$];
    int          m_cyc    [$];
    int          unstable;
    bit          timed_out;

    function automatic logic [63:0] rotr(input bit is64, input logic [63:0] x, input int n);
        logic [31:0] lo;
        if (is64) return (x >> n) | (x << (64 - n));
        lo = x[31:0];
        return {32'd0, (lo >> n) | (lo << (32 - n))};
    endfunction

    // Reference schedule straight from the SHA-2 recurrence.
    task automatic build_ref(input bit is64, input int blk);
        int rounds;
        logic [63:0] mask, a, b, s0, s1;
        rounds = is64 ? 80 : 64;
        mask   = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        for (int t = 0; t < 16; t++) exp_w[blk][t] = msg[blk][t] & mask;
        for (int t = 16; t < rounds; t++) begin
            a  = exp_w[blk][t-15];
            b  = exp_w[blk][t-2];
            s0 = is64 ? (rotr(1, a, 1) ^ rotr(1, a, 8) ^ (a >> 7))
                      : (rotr(0, a, 7) ^ rotr(0, a, 18) ^ (a >> 3));
            s1 = is64 ? (rotr(1, b, 19) ^ rotr(1, b, 61) ^ (b >> 6))
                      : (rotr(0, b, 17) ^ rotr(0, b, 19) ^ (b >> 10));
            exp_w[blk][t] = (s1 + exp_w[blk][t-7] + s0 + exp_w[blk][t-16]) & mask;
        end
    endtask

    task automatic load_abc(input bit is64, input int blk);
        for (int i = 0; i < 16; i++) msg[blk][i] = 64'd0;
        msg[blk][0]  = is64 ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
        msg[blk][15] = is64 ? 64'h0000_0000_0000_0018 : 64'h0000_0000_0000_0018;
        build_ref(is64, blk);
    endtask

    task automatic load_random(input bit is64, input int blk);
        for (int i = 0; i < 16; i++) msg[blk][i] = is64 ? {$urandom, $urandom} : {32'd0, $urandom};
        build_ref(is64, blk);
    endtask

    // Streams nblk blocks through one instance and records every output transfer.
    task automatic run_dut(input bit is64, input int nblk, input bit rnd);
        int rounds, mi, cyc;
        bit mv, wr, held, mr, wv, wl;
        logic [63:0] word, wd, hd;
        logic [6:0]  wi, hi;
        rounds = is64 ? 80 : 64;
        mi = 0; cyc = 0; mv = 0; held = 0; hd = '0; hi = '0;
        cap_data.delete(); cap_idx.delete(); cap_last.delete(); cap_cyc.delete(); m_cyc.delete();
        unstable = 0; timed_out = 0;
        while (cap_data.size() < nblk * rounds) begin
            @(negedge clk);
            if (!mv && mi < nblk * 16) mv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            word = '0;
            if (mi < nblk * 16) word = msg[mi / 16][mi % 16];
            wr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (is64) begin
                m_valid64 = mv; m_data64 = word; w_ready64 = wr;
            end else begin
                m_valid32 = mv; m_data32 = word[31:0]; w_ready32 = wr;
            end
            #1;
            if (is64) begin
                mr = m_ready64; wv = w_valid64; wd = w_data64; wi = w_idx64; wl = w_last64;
            end else begin
                mr = m_ready32; wv = w_valid32; wd = {32'd0, w_data32}; wi = w_idx32; wl = w_last32;
            end
            if (held && (!wv || wd !== hd || wi !== hi)) unstable++;
            held = wv && !wr; hd = wd; hi = wi;
            if (mv && mr) begin
                m_cyc.push_back(cyc);
                mi++;
                mv = 0;
            end
            if (wv && wr) begin
                cap_data.push_back(wd); cap_idx.push_back(wi);
                cap_last.push_back(wl); cap_cyc.push_back(cyc);
            end
            cyc++;
            if (cyc > 4000) begin
                timed_out = 1;
                break;
            end
        end
        @(negedge clk);
        m_valid32 = 0; m_valid64 = 0; w_ready32 = 1; w_ready64 = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (w_valid32 !== 1'b0) begin errors++; $display("FAIL reset_w_valid got=%b exp=0", w_valid32); end
        checks++; if (w_data32 !== 32'd0) begin errors++; $display("FAIL reset_w_data got=%h exp=0", w_data32); end
        checks++; if (w_idx32 !== 7'd0) begin errors++; $display("FAIL reset_w_idx got=%0d exp=0", w_idx32); end
        checks++; if (w_last32 !== 1'b0) begin errors++; $display("FAIL reset_w_last got=%b exp=0", w_last32); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy32); end
        checks++; if (m_ready32 !== 1'b0) begin errors++; $display("FAIL reset_m_ready got=%b exp=0", m_ready32); end
        checks++; if (w_valid64 !== 1'b0 || m_ready64 !== 1'b0) begin errors++; $display("FAIL reset_64 w_valid=%b m_ready=%b exp=0/0", w_valid64, m_ready64); end
        rst = 0;
        @(negedge clk); #1;
        checks++; if (m_ready32 !== 1'b1) begin errors++; $display("FAIL reset_release_m_ready got=%b exp=1", m_ready32); end
    endtask

    task automatic check_stream(input string name, input bit is64, input int nblk);
        int rounds, n, nlast;
        rounds = is64 ? 80 : 64;
        n = cap_data.size();
        checks++; if (timed_out) begin errors++; $display("FAIL %s_timeout got=%0d words exp=%0d", name, n, nblk * rounds); end
        checks++; if (n != nblk * rounds) begin errors++; $display("FAIL %s_count got=%0d exp=%0d", name, n, nblk * rounds); end
        nlast = 0;
        for (int k = 0; k < n && k < nblk * rounds; k++) begin
            checks++;
            if (cap_data[k] !== exp_w[k / rounds][k % rounds] || cap_idx[k] !== 7'(k % rounds)) begin
                errors++;
                $display("FAIL %s_word k=%0d got=%h idx=%0d exp=%h idx=%0d", name, k, cap_data[k], cap_idx[k], exp_w[k / rounds][k % rounds], k % rounds);
            end
            if (cap_last[k] !== (k % rounds == rounds - 1)) nlast++;
        end
        checks++; if (nlast != 0) begin errors++; $display("FAIL %s_w_last wrong on %0d words exp=0", name, nlast); end
    endtask

    task automatic test_abc32();
        load_abc(0, 0);
        run_dut(0, 1, 0);
        check_stream("abc32", 0, 1);
        if (cap_data.size() == 64) begin
            checks++; if (cap_data[16] !== 64'h6162_6380) begin errors++; $display("FAIL abc32_W16 got=%h exp=61626380", cap_data[16]); end
            checks++; if (cap_data[17] !== 64'h000F_0000) begin errors++; $display("FAIL abc32_W17 got=%h exp=000f0000", cap_data[17]); end
            checks++; if (cap_data[63] !== 64'h12B1_EDEB) begin errors++; $display("FAIL abc32_W63 got=%h exp=12b1edeb", cap_data[63]); end
            checks++; if (cap_cyc[63] - cap_cyc[16] != 47) begin errors++; $display("FAIL abc32_bubbles got=%0d cycles exp=47", cap_cyc[63] - cap_cyc[16]); end
        end
    endtask

    task automatic test_random_ready();
        load_abc(0, 0);
        run_dut(0, 1, 1);
        check_stream("rnd_ready", 0, 1);
        checks++; if (unstable != 0) begin errors++; $display("FAIL rnd_ready_stable got=%0d changes exp=0", unstable); end
    endtask

    task automatic test_back_to_back();
        load_abc(0, 0);
        load_random(0, 1);
        run_dut(0, 2, 0);
        check_stream("b2b", 0, 2);
        if (cap_data.size() == 128 && m_cyc.size() == 32) begin
            checks++; if (m_cyc[16] != cap_cyc[63]) begin errors++; $display("FAIL b2b_m0_with_w63 got=%0d exp=%0d", m_cyc[16], cap_cyc[63]); end
            checks++; if (cap_cyc[64] != cap_cyc[63] + 1) begin errors++; $display("FAIL b2b_gap got=%0d exp=%0d", cap_cyc[64], cap_cyc[63] + 1); end
        end
    endtask

    task automatic test_random_blocks();
        load_random(0, 0);
        load_random(0, 1);
        run_dut(0, 2, 1);
        check_stream("rnd_blocks", 0, 2);
        checks++; if (unstable != 0) begin errors++; $display("FAIL rnd_blocks_stable got=%0d changes exp=0", unstable); end
    endtask

    task automatic test_abc64();
        load_abc(1, 0);
        run_dut(1, 1, 0);
        check_stream("abc64", 1, 1);
        if (cap_data.size() == 80) begin
            checks++; if (cap_data[16] !== 64'h6162_6380_0000_0000) begin errors++; $display("FAIL abc64_W16 got=%h exp=6162638000000000", cap_data[16]); end
        end
        load_random(1, 0);
        load_random(1, 1);
        run_dut(1, 2, 1);
        check_stream("rnd64", 1, 2);
    endtask

    task automatic test_rst_mid();
        int mi, cyc;
        bit seen;
        load_abc(0, 0);
        mi = 0; cyc = 0; seen = 0;
        while (!seen && cyc < 500) begin
            @(negedge clk);
            m_valid32 = (mi < 16);
            m_data32  = msg[0][mi % 16][31:0];
            w_ready32 = 1;
            #1;
            if (w_valid32 && w_idx32 == 7'd30) seen = 1;
            else if (m_valid32 && m_ready32) mi++;
            cyc++;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_mid_reach_idx30 got=%0d cycles exp=idx 30", cyc); end
        m_valid32 = 0;
        rst = 1;
        @(negedge clk); #1;
        checks++; if (w_valid32 !== 1'b0 || busy32 !== 1'b0) begin errors++; $display("FAIL rst_mid_flush w_valid=%b busy=%b exp=0/0", w_valid32, busy32); end
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++; if (w_valid32 !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet cycle=%0d got=%b exp=0", i, w_valid32); end
        end
        run_dut(0, 1, 0);
        check_stream("rst_mid_fresh", 0, 1);
    endtask

`ifdef SHA2_MSG_SCHED_ABORT_EN
    task automatic test_abort();
        int mi, cyc;
        bit seen;
        load_abc(0, 0);
        mi = 0; cyc = 0; seen = 0;
        while (!seen && cyc < 500) begin
            @(negedge clk);
            m_valid32 = (mi < 16);
            m_data32  = msg[0][mi % 16][31:0];
            w_ready32 = 1;
            #1;
            if (w_valid32 && w_idx32 == 7'd20) seen = 1;
            else if (m_valid32 && m_ready32) mi++;
            cyc++;
        end
        checks++; if (!seen) begin errors++; $display("FAIL abort_reach_idx20 got=%0d cycles exp=idx 20", cyc); end
        m_valid32 = 0;
        w_ready32 = 0;
        abort32   = 1;
        @(negedge clk);
        abort32 = 0;
        @(negedge clk); #1;
        checks++; if (w_valid32 !== 1'b0) begin errors++; $display("FAIL abort_w_valid got=%b exp=0", w_valid32); end
        checks++; if (m_ready32 !== 1'b1) begin errors++; $display("FAIL abort_m_ready got=%b exp=1", m_ready32); end
        checks++; if (w_idx32 !== 7'd0 || busy32 !== 1'b0) begin errors++; $display("FAIL abort_state w_idx=%0d busy=%b exp=0/0", w_idx32, busy32); end
        w_ready32 = 1;
        run_dut(0, 1, 0);
        check_stream("abort_fresh", 0, 1);
    endtask
`endif

    initial begin
        rst = 1;
        m_valid32 = 0; m_data32 = '0; w_ready32 = 1;
        m_valid64 = 0; m_data64 = '0; w_ready64 = 1;
`ifdef SHA2_MSG_SCHED_ABORT_EN
        abort32 = 0;
`endif
        test_reset();
        test_abc32();
        test_random_ready();
        test_back_to_back();
        test_random_blocks();
        test_abc64();
        test_rst_mid();
`ifdef SHA2_MSG_SCHED_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
